// File: rtl/ram8x16_pkg.sv
// ram_pkg: shared word width and word type for the ram8x16 memory slice
package ram_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram8x16_register16.sv
// register16: 16-bit load register with async active-low clear
//   CLK in, RST_N in (async clear), in[15:0] data, load in (only a clean 1 loads), out[15:0] stored word
module register16
  import ram_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  word_t in,
  input  logic  load,
  output word_t out
);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) out <= '0;
    else if (load) out <= in;
endmodule

// File: rtl/ram8x16.sv
// ram8x16: 8-word x 16-bit RAM, clocked write, combinational read at a shared address
//   CLK in, RST_N in (async clear of all words), in[WIDTH-1:0] write data,
//   write_enable in, address[ADDR_W-1:0] in, out[WIDTH-1:0] = mem[address]
module ram8x16
  import ram_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  in,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);
  logic [DEPTH-1:0] load;
  word_t            q [DEPTH];
  // an X/Z write_enable yields a non-1 load, which the register treats as hold
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign load[i] = write_enable & (address == ADDR_W'(i));
    register16 u_reg (.CLK(CLK), .RST_N(RST_N), .in(in), .load(load[i]), .out(q[i]));
  end
  always_comb
    case (address)
      3'd0: out = q[0];
      3'd1: out = q[1];
      3'd2: out = q[2];
      3'd3: out = q[3];
      3'd4: out = q[4];
      3'd5: out = q[5];
      3'd6: out = q[6];
      default: out = q[7];
    endcase
endmodule

// File: tb/tb_ram8x16.sv
// tb_ram8x16: directed self-checking bench for ram8x16
module tb_ram8x16;
  logic        CLK = 0;
  logic        RST_N = 0;
  logic [15:0] in = '0;
  logic        write_enable = 0;
  logic [2:0]  address = '0;
  logic [15:0] out;
  logic [15:0] exp_mem [8];
  int n_chk = 0;
  int n_fail = 0;

  ram8x16 dut (.CLK(CLK), .RST_N(RST_N), .in(in), .write_enable(write_enable),
               .address(address), .out(out));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 chk($sformatf("%s[%0d]", tag, a), out, exp_mem[a]);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge CLK);
    address = a;
    in = d;
    write_enable = 1;
    @(posedge CLK);
    #1 write_enable = 0;
  endtask

  initial begin
    foreach (exp_mem[i]) exp_mem[i] = '0;
    #2 sweep("por");
    @(negedge CLK) RST_N = 1;
    for (int a = 0; a < 8; a++) wr(3'(a), 16'($urandom));
    @(negedge CLK);
    #1 RST_N = 0;
    sweep("rst_sweep");
    @(negedge CLK) RST_N = 1;
    wr(0, 16'hAAAA); wr(1, 16'hBBBB); wr(2, 16'hCCCC); wr(3, 16'hDDDD);
    wr(4, 16'hEEEE); wr(5, 16'hFFFF); wr(6, 16'h1234); wr(7, 16'h0505);
    exp_mem[0] = 16'hAAAA; exp_mem[1] = 16'hBBBB; exp_mem[2] = 16'hCCCC; exp_mem[3] = 16'hDDDD;
    exp_mem[4] = 16'hEEEE; exp_mem[5] = 16'hFFFF; exp_mem[6] = 16'h1234; exp_mem[7] = 16'h0505;
    @(negedge CLK);
    sweep("fill");
    @(negedge CLK);
    write_enable = 0;
    in = 16'h5A5A;
    address = 3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    sweep("hold");
    @(negedge CLK);
    write_enable = 1'bx;
    address = 4;
    in = 16'h0BAD;
    @(posedge CLK);
    #1 write_enable = 0;
    sweep("x_we");
    @(negedge CLK);
    address = 2;
    in = 16'h9999;
    write_enable = 1;
    #1 chk("raw_before", out, 16'hCCCC);
    @(posedge CLK);
    #1 chk("raw_after", out, 16'h9999);
    write_enable = 0;
    exp_mem[2] = 16'h9999;
    wr(7, 16'hFFFF);
    exp_mem[7] = 16'hFFFF;
    @(negedge CLK);
    sweep("iso");
    @(negedge CLK);
    address = 5;
    in = 16'h1111;
    write_enable = 1;
    #2 RST_N = 0;
    #1 chk("mid_rst_now", out, 16'h0000);
    foreach (exp_mem[i]) exp_mem[i] = '0;
    repeat (2) @(posedge CLK);
    #1 chk("mid_rst_edges", out, 16'h0000);
    @(negedge CLK);
    write_enable = 0;
    RST_N = 1;
    sweep("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
